// File: rtl/axi_burst_checker.sv
// AXI4 write-slave sink that checks generator bursts (incrementing 16-bit word replicated across the bus),
// WSTRB, WLAST and AWSIZE, returns one B per burst, and keeps bring-up counters and sticky error flags.
module axi_burst_checker #(
  parameter int unsigned DATA_WIDTH    = 512,
  parameter int unsigned ADDR_WIDTH    = 64,
  parameter int unsigned AW_FIFO_DEPTH = 4,
  parameter int unsigned B_FIFO_DEPTH  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [7:0]              S_AXI_AWLEN,
  input  logic [2:0]              S_AXI_AWSIZE,
  input  logic                    S_AXI_AWVALID,
  output logic                    S_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                    S_AXI_WLAST,
  input  logic                    S_AXI_WVALID,
  output logic                    S_AXI_WREADY,
  output logic [1:0]              S_AXI_BRESP,
  output logic                    S_AXI_BVALID,
  input  logic                    S_AXI_BREADY,
  input  logic                    clear,
  output logic [31:0]             beat_count,
  output logic [31:0]             burst_count,
  output logic [31:0]             error_count,
  output logic [3:0]              err_flags
);

  localparam int unsigned STRB_W    = DATA_WIDTH / 8;
  localparam int unsigned WORDS     = DATA_WIDTH / 16;
  localparam int unsigned SIZE_LOG2 = $clog2(STRB_W);
  localparam int unsigned AW_PTR_W  = $clog2(AW_FIFO_DEPTH);
  localparam int unsigned AW_CNT_W  = AW_PTR_W + 1;
  localparam int unsigned B_PTR_W   = $clog2(B_FIFO_DEPTH);
  localparam int unsigned B_CNT_W   = B_PTR_W + 1;

  typedef struct packed {
    logic [7:0] len;
    logic       size_err;
  } aw_entry_t;

  aw_entry_t            aw_mem [AW_FIFO_DEPTH];
  logic [AW_PTR_W-1:0]  aw_wr, aw_rd;
  logic [AW_CNT_W-1:0]  aw_cnt, aw_cnt_next;
  aw_entry_t            aw_head, aw_in;

  logic                 b_mem [B_FIFO_DEPTH];
  logic [B_PTR_W-1:0]   b_wr, b_rd, b_rd_next;
  logic [B_CNT_W-1:0]   b_cnt, b_cnt_next;

  logic [15:0]          exp_word;
  logic [7:0]           beat_idx;
  logic                 burst_err_acc;

  logic aw_hs, w_hs, b_hs;
  logic data_err, strb_err, wlast_err, beat_err, last_beat, burst_end, b_push_data, b_head_next;
  logic [1:0]  err_inc;
  logic [32:0] err_sum;
  logic        unused_addr;

  assign unused_addr = ^S_AXI_AWADDR;

  assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID && S_AXI_WREADY;
  assign b_hs  = S_AXI_BVALID && S_AXI_BREADY;

  assign aw_head     = aw_mem[aw_rd];
  assign aw_in.len      = S_AXI_AWLEN;
  assign aw_in.size_err = S_AXI_AWSIZE != 3'(SIZE_LOG2);

  // Per-beat checks against the head AW entry; burst end is decided by AWLEN, not WLAST
  assign data_err    = S_AXI_WDATA != {WORDS{exp_word}};
  assign strb_err    = S_AXI_WSTRB != {STRB_W{1'b1}};
  assign last_beat   = beat_idx == aw_head.len;
  assign wlast_err   = S_AXI_WLAST != last_beat;
  assign beat_err    = data_err || strb_err || wlast_err;
  assign burst_end   = w_hs && last_beat;
  assign b_push_data = burst_err_acc || beat_err || aw_head.size_err;

  assign err_inc = 2'(w_hs && beat_err) + 2'(burst_end && aw_head.size_err);
  assign err_sum = 33'(error_count) + 33'(err_inc);

  assign aw_cnt_next = aw_cnt + AW_CNT_W'(aw_hs) - AW_CNT_W'(burst_end);
  assign b_cnt_next  = b_cnt + B_CNT_W'(burst_end) - B_CNT_W'(b_hs);
  assign b_rd_next   = b_rd + B_PTR_W'(b_hs);
  // The entry landing at the head this cycle may be the one being pushed right now
  assign b_head_next = (burst_end && (b_wr == b_rd_next)) ? b_push_data : b_mem[b_rd_next];

  always_ff @(posedge clk) begin
    if (aw_hs) aw_mem[aw_wr] <= aw_in;
    if (burst_end) b_mem[b_wr] <= b_push_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      aw_wr         <= '0;
      aw_rd         <= '0;
      aw_cnt        <= '0;
      b_wr          <= '0;
      b_rd          <= '0;
      b_cnt         <= '0;
      beat_idx      <= '0;
      burst_err_acc <= 1'b0;
      S_AXI_AWREADY <= 1'b0;
      S_AXI_WREADY  <= 1'b0;
      S_AXI_BVALID  <= 1'b0;
      S_AXI_BRESP   <= 2'b00;
    end else begin
      if (aw_hs) aw_wr <= aw_wr + AW_PTR_W'(1);
      if (burst_end) begin
        aw_rd         <= aw_rd + AW_PTR_W'(1);
        b_wr          <= b_wr + B_PTR_W'(1);
        beat_idx      <= '0;
        burst_err_acc <= 1'b0;
      end else if (w_hs) begin
        beat_idx      <= beat_idx + 8'd1;
        burst_err_acc <= burst_err_acc || beat_err;
      end
      b_rd          <= b_rd_next;
      aw_cnt        <= aw_cnt_next;
      b_cnt         <= b_cnt_next;
      S_AXI_AWREADY <= aw_cnt_next != AW_CNT_W'(AW_FIFO_DEPTH);
      S_AXI_WREADY  <= (aw_cnt_next != '0) && (b_cnt_next != B_CNT_W'(B_FIFO_DEPTH));
      S_AXI_BVALID  <= b_cnt_next != '0;
      S_AXI_BRESP   <= (b_cnt_next != '0) ? {b_head_next, 1'b0} : 2'b00;
    end
  end

  // Statistics; clear wins over that cycle's events but leaves in-flight bursts alone
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exp_word    <= 16'h0001;
      beat_count  <= '0;
      burst_count <= '0;
      error_count <= '0;
      err_flags   <= '0;
    end else if (clear) begin
      exp_word    <= 16'h0001;
      beat_count  <= '0;
      burst_count <= '0;
      error_count <= '0;
      err_flags   <= '0;
    end else begin
      if (w_hs) begin
        exp_word     <= S_AXI_WDATA[15:0] + 16'd1;
        beat_count   <= beat_count + 32'd1;
        err_flags[0] <= err_flags[0] || data_err;
        err_flags[1] <= err_flags[1] || strb_err;
        err_flags[2] <= err_flags[2] || wlast_err;
      end
      if (burst_end) begin
        burst_count  <= burst_count + 32'd1;
        err_flags[3] <= err_flags[3] || aw_head.size_err;
      end
      error_count <= err_sum[32] ? 32'hFFFF_FFFF : err_sum[31:0];
    end
  end

endmodule
